count_result_fifo: RTL and testbench

//  Downstream of the 4-channel gated counter. Captures one result record per measurement
//  (gate count time + 4 channel counts) on each rising edge of the counter's stop pulse.

---
 rtl/count_result_fifo_if.sv | 23 ++
 rtl/count_result_fifo.sv | 117 +++++++++++
 tb/tb_count_result_fifo.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/count_result_fifo_if.sv
// Bus bundle between the gated counter / host register bus and the result FIFO.
// The FIFO uses the slave side; the counter and host drive the master side.
interface count_result_fifo_if;
    logic         stop_in;
    logic [31:0]  time_in;
    logic [127:0] ch_in;
    logic [7:0]   addr;
    logic [7:0]   data_in;
    logic         we;
    logic         rd;
    logic [7:0]   data_out;
    logic         irq;

    modport slave (
        input  stop_in, time_in, ch_in, addr, data_in, we, rd,
        output data_out, irq
    );

    modport master (
        output stop_in, time_in, ch_in, addr, data_in, we, rd,
        input  data_out, irq
    );
endinterface

// File: rtl/count_result_fifo.sv
// Result FIFO for the 4-channel gated counter: one 20-byte record per stop rising edge,
// read back bytewise through a 4-register window on the 8-bit host bus.
module count_result_fifo #(
    parameter int unsigned DEPTH     = 16,
    parameter logic [7:0]  BASE_ADDR = 8'h40
) (
    input logic                clk,
    input logic                reset,
    count_result_fifo_if.slave bus
);
    localparam int unsigned   PW        = $clog2(DEPTH);
    localparam int unsigned   CW        = PW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [4:0]    LAST_BYTE = 5'd19;
    localparam logic [7:0]    A_STATUS  = BASE_ADDR;
    localparam logic [7:0]    A_COUNT   = BASE_ADDR + 8'd1;
    localparam logic [7:0]    A_DATA    = BASE_ADDR + 8'd2;
    localparam logic [7:0]    A_CTRL    = BASE_ADDR + 8'd3;

    logic [159:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    byte_idx_q, byte_idx_d;
    logic          ovf_q, ovf_d;
    logic          stop_q;
    logic          irq_q;
    logic [7:0]    data_out_q, data_out_d;

    logic          empty, full, stop_rise, capture, pop_byte, pop_rec;
    logic          ctrl_wr, flush, ovf_clr, ovf_set;
    logic [159:0]  rd_rec;
    logic          unused_data_bits;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign stop_rise = bus.stop_in & ~stop_q;
    // full is taken from the registered count, so a same-cycle pop cannot make room
    assign capture   = stop_rise & ~full;
    assign ovf_set   = stop_rise & full & ~flush;
    assign pop_byte  = bus.rd & (bus.addr == A_DATA) & ~empty;
    assign pop_rec   = pop_byte & (byte_idx_q == LAST_BYTE);
    assign ctrl_wr   = bus.we & (bus.addr == A_CTRL);
    assign flush     = ctrl_wr & bus.data_in[1];
    assign ovf_clr   = ctrl_wr & bus.data_in[0];
    assign rd_rec    = mem_q[rd_ptr_q];

    assign unused_data_bits = ^bus.data_in[7:2];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        byte_idx_d = byte_idx_q;
        ovf_d      = ovf_q;

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            byte_idx_d = '0;
        end else begin
            if (capture) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_byte) byte_idx_d = pop_rec ? 5'd0 : byte_idx_q + 5'd1;
            if (pop_rec) rd_ptr_d = rd_ptr_q + PW'(1);
            case ({capture, pop_rec})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        // A drop in the same cycle as a clear still leaves ovf set
        if (ovf_clr) ovf_d = 1'b0;
        if (ovf_set) ovf_d = 1'b1;
    end

    always_comb begin
        data_out_d = 8'h00;
        case (bus.addr)
            A_STATUS: data_out_d = {5'b0, ovf_q, full, empty};
            A_COUNT:  data_out_d = 8'(count_q);
            A_DATA:   data_out_d = empty ? 8'h00 : rd_rec[{byte_idx_q, 3'b000} +: 8];
            default:  data_out_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            byte_idx_q <= '0;
            ovf_q      <= 1'b0;
            stop_q     <= 1'b0;
            irq_q      <= 1'b0;
            data_out_q <= 8'h00;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            byte_idx_q <= byte_idx_d;
            ovf_q      <= ovf_d;
            stop_q     <= bus.stop_in;
            irq_q      <= (count_d != '0);
            data_out_q <= data_out_d;
        end
    end

    // Record storage is not reset; byte 0 of a record is the low byte of time_in
    always_ff @(posedge clk) begin
        if (capture && !flush) mem_q[wr_ptr_q] <= {bus.ch_in, bus.time_in};
    end

    assign bus.data_out = data_out_q;
    assign bus.irq      = irq_q;
endmodule

// File: tb/tb_count_result_fifo.sv
// Testbench for count_result_fifo: directed scenarios plus a randomized run, every cycle
// compared against a queue-based model of the record buffer.
module tb_count_result_fifo;
    localparam int         DEPTH = 16;
    localparam logic [7:0] BASE  = 8'h40;
    localparam logic [7:0] A_ST  = BASE;
    localparam logic [7:0] A_CNT = BASE + 8'd1;
    localparam logic [7:0] A_DAT = BASE + 8'd2;
    localparam logic [7:0] A_CTL = BASE + 8'd3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    count_result_fifo_if bus();

    count_result_fifo #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [159:0] m_q [$];
    int           m_bidx = 0;
    logic         m_ovf  = 1'b0;
    logic         m_stop = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, compare data_out/irq after the edge
    task automatic step(input logic stop, input logic we, input logic rd,
                        input logic [7:0] addr, input logic [7:0] din);
        logic [7:0]   exp_d;
        logic         full, rise, flush, clr, popr;
        logic [159:0] rec;
        bus.stop_in = stop;
        bus.we      = we;
        bus.rd      = rd;
        bus.addr    = addr;
        bus.data_in = din;
        rec   = {bus.ch_in, bus.time_in};
        full  = (m_q.size() == DEPTH);
        rise  = stop && !m_stop;
        exp_d = 8'h00;
        if (addr == A_ST)
            exp_d = {5'b0, m_ovf, full, m_q.size() == 0};
        else if (addr == A_CNT)
            exp_d = 8'(m_q.size());
        else if (addr == A_DAT && m_q.size() != 0)
            exp_d = m_q[0][8*m_bidx +: 8];
        flush = we && addr == A_CTL && din[1];
        clr   = we && addr == A_CTL && din[0];
        popr  = 1'b0;
        if (flush) begin
            m_q.delete();
            m_bidx = 0;
        end else begin
            if (rd && addr == A_DAT && m_q.size() != 0) begin
                m_bidx++;
                if (m_bidx == 20) begin
                    m_bidx = 0;
                    popr   = 1'b1;
                end
            end
            if (rise && !full) m_q.push_back(rec);
            if (popr) void'(m_q.pop_front());
        end
        if (clr) m_ovf = 1'b0;
        if (rise && full && !flush) m_ovf = 1'b1;
        m_stop = stop;
        @(posedge clk);
        #1;
        check_eq("data_out", {24'h0, bus.data_out}, {24'h0, exp_d});
        check_eq("irq", {31'h0, bus.irq}, {31'h0, m_q.size() != 0});
    endtask

    task automatic rd_reg(input string tag, input logic [7:0] a, input logic [7:0] req);
        step(bus.stop_in, 1'b0, 1'b0, a, 8'h00);
        check_eq(tag, {24'h0, bus.data_out}, {24'h0, req});
    endtask

    task automatic capture(input logic [31:0] t, input logic [127:0] ch);
        bus.time_in = t;
        bus.ch_in   = ch;
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic read_bytes(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, A_DAT, 8'h00);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #2;
        check_eq("rst_data_out", {24'h0, bus.data_out}, 32'h0);
        check_eq("rst_irq", {31'h0, bus.irq}, 32'h0);
        m_q.delete();
        m_bidx = 0;
        m_ovf  = 1'b0;
        m_stop = 1'b0;
        bus.stop_in = 1'b0;
        bus.we      = 1'b0;
        bus.rd      = 1'b0;
        bus.addr    = 8'h00;
        bus.data_in = 8'h00;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [7:0] exp8 [8];

    initial begin
        bus.stop_in = 1'b0;
        bus.time_in = '0;
        bus.ch_in   = '0;
        bus.addr    = 8'h00;
        bus.data_in = 8'h00;
        bus.we      = 1'b0;
        bus.rd      = 1'b0;
        #1;
        apply_reset();

        // Reset state; rd strobes on an empty buffer do nothing
        read_bytes(3);
        rd_reg("status_reset", A_ST, 8'h01);
        rd_reg("count_reset", A_CNT, 8'h00);
        rd_reg("data_empty", A_DAT, 8'h00);

        // Single record, bytewise readout
        exp8 = '{8'hE8, 8'h03, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        capture(32'h0000_03E8, {96'h0, 32'h1234_5678});
        rd_reg("count_one", A_CNT, 8'h01);
        check_eq("irq_one", {31'h0, bus.irq}, 32'h1);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b1, A_DAT, 8'h00);
            if (i < 8) check_eq("rec_byte", {24'h0, bus.data_out}, {24'h0, exp8[i]});
        end
        rd_reg("count_drained", A_CNT, 8'h00);
        rd_reg("status_drained", A_ST, 8'h01);

        // Level held high captures once
        bus.time_in = $urandom;
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        rd_reg("count_level", A_CNT, 8'h01);
        read_bytes(20);

        // Overflow: DEPTH+1 edges
        for (int t = 1; t <= DEPTH + 1; t++)
            capture(32'(t), {$urandom, $urandom, $urandom, $urandom});
        rd_reg("count_full", A_CNT, 8'h10);
        rd_reg("status_full_ovf", A_ST, 8'h06);
        for (int r = 0; r < DEPTH; r++) begin
            for (int b = 0; b < 20; b++) begin
                step(1'b0, 1'b0, 1'b1, A_DAT, 8'h00);
                if (b == 0) check_eq("rec_time", {24'h0, bus.data_out}, 32'(r + 1));
            end
        end
        rd_reg("status_ovf_empty", A_ST, 8'h05);
        step(1'b0, 1'b1, 1'b0, A_CTL, 8'h01);
        rd_reg("status_ovf_clr", A_ST, 8'h01);

        // Capture coinciding with a mid-record pop
        capture(32'hA3A2_A1A0, {32'h0, 32'h0, 32'hC3C2_C1C0, 32'hB3B2_B1B0});
        capture($urandom, {$urandom, $urandom, $urandom, $urandom});
        read_bytes(7);
        bus.time_in = $urandom;
        step(1'b1, 1'b0, 1'b1, A_DAT, 8'h00);
        check_eq("byte7", {24'h0, bus.data_out}, 32'hB3);
        step(1'b0, 1'b0, 1'b0, A_DAT, 8'h00);
        check_eq("byte8", {24'h0, bus.data_out}, 32'hC0);
        rd_reg("count_cap_pop", A_CNT, 8'h03);
        read_bytes(52);
        rd_reg("count_after_wrap", A_CNT, 8'h00);

        // Flush with a coincident edge; ovf preserved
        for (int t = 0; t < DEPTH + 1; t++)
            capture($urandom, {$urandom, $urandom, $urandom, $urandom});
        step(1'b1, 1'b1, 1'b0, A_CTL, 8'h02);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        rd_reg("count_flush", A_CNT, 8'h00);
        rd_reg("status_flush", A_ST, 8'h05);
        step(1'b0, 1'b1, 1'b0, A_CTL, 8'h01);
        for (int t = 0; t < 3; t++)
            capture($urandom, {$urandom, $urandom, $urandom, $urandom});
        step(1'b1, 1'b1, 1'b0, A_CTL, 8'h02);
        rd_reg("count_flush3", A_CNT, 8'h00);
        rd_reg("status_flush3", A_ST, 8'h01);

        // Asynchronous reset in the middle of a readout
        capture($urandom, {$urandom, $urandom, $urandom, $urandom});
        capture($urandom, {$urandom, $urandom, $urandom, $urandom});
        read_bytes(5);
        apply_reset();
        rd_reg("status_after_rst", A_ST, 8'h01);
        rd_reg("count_after_rst", A_CNT, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] a;
            logic       w;
            int         sel;
            sel = int'($urandom % 8);
            case (sel)
                0, 1, 2, 3: a = BASE + 8'(sel);
                4:          a = A_DAT;
                5:          a = 8'h00;
                6:          a = 8'h44;
                default:    a = 8'h3F;
            endcase
            w = ($urandom % 40) == 0;
            bus.time_in = $urandom;
            bus.ch_in   = {$urandom, $urandom, $urandom, $urandom};
            step(1'($urandom % 2), w, 1'($urandom % 2), a, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
